// File: rtl/switch_arbiter_rr_pkg.sv
// Router-wide constants and types for the switch allocator (noc_params).
// Port order follows the mesh router: LOCAL, NORTH, SOUTH, WEST, EAST.
package switch_arbiter_rr_pkg;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef logic [PORT_SIZE-1:0] port_idx_t;
    typedef logic [VC_SIZE-1:0]   vc_idx_t;

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    // Encodings at or above PORT_NUM do not name a real output port.
    function automatic logic port_in_range(input port_idx_t p);
        return p < PORT_SIZE'(PORT_NUM);
    endfunction

endpackage

// File: rtl/switch_arbiter_rr_if.sv
// Allocator bus between the input block / downstream links and the switch
// allocator. grant_cnt_o exists only when SA_STATS_EN is defined.
interface switch_arbiter_rr_if;
    import switch_arbiter_rr_pkg::*;

    logic      [PORT_NUM-1:0][VC_NUM-1:0] req_i;
    port_idx_t [PORT_NUM-1:0][VC_NUM-1:0] out_port_i;
    vc_idx_t   [PORT_NUM-1:0][VC_NUM-1:0] downstream_vc_i;
    logic      [PORT_NUM-1:0][VC_NUM-1:0] on_off_i;
    logic      [PORT_NUM-1:0][VC_NUM-1:0] vc_grant_o;
    port_idx_t [PORT_NUM-1:0]             xbar_sel_o;
    logic      [PORT_NUM-1:0]             valid_flit_o;
`ifdef SA_STATS_EN
    logic      [PORT_NUM-1:0][15:0]       grant_cnt_o;

    modport master (
        output req_i, out_port_i, downstream_vc_i, on_off_i,
        input  vc_grant_o, xbar_sel_o, valid_flit_o, grant_cnt_o
    );
    modport slave (
        input  req_i, out_port_i, downstream_vc_i, on_off_i,
        output vc_grant_o, xbar_sel_o, valid_flit_o, grant_cnt_o
    );
`else
    modport master (
        output req_i, out_port_i, downstream_vc_i, on_off_i,
        input  vc_grant_o, xbar_sel_o, valid_flit_o
    );
    modport slave (
        input  req_i, out_port_i, downstream_vc_i, on_off_i,
        output vc_grant_o, xbar_sel_o, valid_flit_o
    );
`endif

endinterface

// File: rtl/switch_arbiter_rr_rr_arbiter.sv
// N-way round-robin arbiter: search starts at the pointer and wraps to 0;
// the pointer moves to one past the winner only when update_en is high.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          update_en,
    output logic [N-1:0]  grant,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr;
    logic [IW:0]   cand;

    // Pick the first requester at or after the pointer, wrapping at N.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!any && req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
        grant = '0;
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

    // Advance the pointer past an accepted winner.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (update_en && any) begin
            ptr <= (idx == IW'(N-1)) ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/switch_arbiter_rr.sv
// Separable input-first switch allocator for the 5-port, 2-VC mesh router.
// Stage 1 picks one eligible VC per input, stage 2 one input per output.
// Optional macro SA_STATS_EN adds saturating per-output grant counters.
module switch_arbiter_rr
    import switch_arbiter_rr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    switch_arbiter_rr_if.slave sa
);

    logic      [PORT_NUM-1:0][VC_NUM-1:0]   eligible;
    logic      [PORT_NUM-1:0][VC_NUM-1:0]   s1_grant;
    logic      [PORT_NUM-1:0]               s1_valid;
    vc_idx_t   [PORT_NUM-1:0]               s1_vc;
    port_idx_t [PORT_NUM-1:0]               s1_target;
    logic      [PORT_NUM-1:0]               in_won;

    logic      [PORT_NUM-1:0][PORT_NUM-1:0] s2_req;     // [output][input]
    logic      [PORT_NUM-1:0][PORT_NUM-1:0] s2_grant;   // [output][input]
    logic      [PORT_NUM-1:0][PORT_NUM-1:0] s2_grant_t; // [input][output]
    logic      [PORT_NUM-1:0]               s2_any;
    port_idx_t [PORT_NUM-1:0]               s2_idx;

    logic      [PORT_NUM-1:0]               valid_q;
    port_idx_t [PORT_NUM-1:0]               xbar_q;
    port_idx_t [PORT_NUM-1:0]               xbar_next;

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_input
        for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
            assign eligible[i][v] = sa.req_i[i][v]
                && port_in_range(sa.out_port_i[i][v])
                && sa.on_off_i[sa.out_port_i[i][v]][sa.downstream_vc_i[i][v]];
        end

        // The stage-1 pointer only moves once the input also wins stage 2.
        rr_arbiter #(.N(VC_NUM)) u_s1 (
            .clk       (clk),
            .rst       (rst),
            .req       (eligible[i]),
            .update_en (in_won[i]),
            .grant     (s1_grant[i]),
            .any       (s1_valid[i]),
            .idx       (s1_vc[i])
        );

        assign s1_target[i] = sa.out_port_i[i][s1_vc[i]];

        for (genvar o = 0; o < PORT_NUM; o++) begin : g_xpose
            assign s2_req[o][i]     = s1_valid[i] && (s1_target[i] == PORT_SIZE'(o));
            assign s2_grant_t[i][o] = s2_grant[o][i];
        end

        assign in_won[i]        = |s2_grant_t[i];
        assign sa.vc_grant_o[i] = (rst && in_won[i]) ? s1_grant[i] : '0;
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_output
        rr_arbiter #(.N(PORT_NUM)) u_s2 (
            .clk       (clk),
            .rst       (rst),
            .req       (s2_req[o]),
            .update_en (1'b1),
            .grant     (s2_grant[o]),
            .any       (s2_any[o]),
            .idx       (s2_idx[o])
        );

        assign xbar_next[o] = s2_any[o] ? s2_idx[o] : xbar_q[o];
    end

    // Register crossbar select and flit-valid toward the downstream router.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            xbar_q  <= '0;
        end else begin
            valid_q <= s2_any;
            xbar_q  <= xbar_next;
        end
    end

    assign sa.valid_flit_o = valid_q;
    assign sa.xbar_sel_o   = xbar_q;

`ifdef SA_STATS_EN
    logic [PORT_NUM-1:0][15:0] cnt_q;
    logic [PORT_NUM-1:0][15:0] cnt_next;

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_stats
        assign cnt_next[o] = (s2_any[o] && (cnt_q[o] != 16'hFFFF)) ? cnt_q[o] + 16'd1
                                                                     : cnt_q[o];
    end

    // Per-output grant counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_next;
        end
    end

    assign sa.grant_cnt_o = cnt_q;
`endif

endmodule
